// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Definitions shared by uart_tx and uart_rx. Holds the FSM state
//            encoding, the default baud oversampling factor and the
//            even-parity helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default number of baud ticks per serial bit (oversampling factor).
  localparam int UART_N_TICK = 16;

  // Frame state encoding, shared by the transmitter and the receiver.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity: the bit that makes the total count of ones even.
  // Callers zero-extend narrower words, which leaves the XOR unchanged.
  function automatic logic even_parity(input logic [31:0] bits);
    return ^bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmitter. Sends one frame per accepted request:
//            start bit, N_DATA data bits LSB first, optional even parity
//            bit, M_STOP stop bits. Each bit lasts N_TICK baud-tick pulses
//            supplied externally on i_valid.
// Macro    : UART_TX_PARITY_EN - when defined, an even parity bit is sent
//            between the last data bit and the first stop bit.
// Ports    : i_clock    - clock
//            i_reset    - synchronous active-high reset
//            i_valid    - baud tick enable (N_TICK x baud rate pulses)
//            i_data     - word to send, sampled only when a frame is accepted
//            i_tx_start - frame request, honoured only while idle
//            o_tx       - registered serial line, idle high
//            o_tx_done  - one-cycle pulse when the frame has finished
//            o_busy     - high whenever a frame is in progress
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int N_DATA      = 8,
  parameter int LOG2_N_DATA = 4,
  parameter int M_STOP      = 1,
  parameter int LOG2_M_STOP = 1,
  parameter int N_TICK      = UART_N_TICK
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [N_DATA-1:0] i_data,
  input  logic              i_tx_start,
  output logic              o_tx,
  output logic              o_tx_done,
  output logic              o_busy
);

  localparam int TICK_W = (N_TICK > 1) ? $clog2(N_TICK) : 1;
  localparam logic [TICK_W-1:0]      TICK_LAST = TICK_W'(N_TICK - 1);
  localparam logic [LOG2_N_DATA-1:0] IDX_LAST  = LOG2_N_DATA'(N_DATA - 1);
  localparam logic [LOG2_M_STOP-1:0] STOP_LAST = LOG2_M_STOP'(M_STOP - 1);

  uart_state_e            state, state_next;
  logic [TICK_W-1:0]      tick, tick_next;
  logic [LOG2_N_DATA-1:0] idx, idx_next;
  logic [LOG2_M_STOP-1:0] stop_cnt, stop_next;
  logic [N_DATA-1:0]      shreg, shreg_next;
  logic                   tx_next;
  logic                   done_next;
  logic                   bit_end;
`ifdef UART_TX_PARITY_EN
  // Parity is captured at acceptance because the shift register is
  // consumed while the data bits go out.
  logic                   par_bit, par_next;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      tick      <= '0;
      idx       <= '0;
      stop_cnt  <= '0;
      shreg     <= '0;
      o_tx      <= 1'b1;
      o_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      tick      <= tick_next;
      idx       <= idx_next;
      stop_cnt  <= stop_next;
      shreg     <= shreg_next;
      o_tx      <= tx_next;
      o_tx_done <= done_next;
`ifdef UART_TX_PARITY_EN
      par_bit   <= par_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    tick_next  = tick;
    idx_next   = idx;
    stop_next  = stop_cnt;
    shreg_next = shreg;
    done_next  = 1'b0;
    bit_end    = 1'b0;
    tx_next    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_next   = par_bit;
`endif

    // The tick counter only runs inside a frame; bit_end marks the tick
    // that closes the current bit period.
    if (state != ST_IDLE && i_valid) begin
      if (tick == TICK_LAST) begin
        tick_next = '0;
        bit_end   = 1'b1;
      end else begin
        tick_next = tick + 1'b1;
      end
    end

    case (state)
      ST_IDLE: begin
        if (i_tx_start) begin
          shreg_next = i_data;
          idx_next   = '0;
          stop_next  = '0;
          tick_next  = '0;
          state_next = ST_START;
`ifdef UART_TX_PARITY_EN
          par_next   = even_parity(32'(i_data));
`endif
        end
      end
      ST_START: begin
        if (bit_end) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_next = shreg >> 1;
          if (idx == IDX_LAST) begin
            idx_next   = '0;
`ifdef UART_TX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (stop_cnt == STOP_LAST) begin
            stop_next  = '0;
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            stop_next = stop_cnt + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // The line is registered from the upcoming state so o_tx changes on
    // the same edge as the state register.
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = par_next;
`endif
      default:   tx_next = 1'b1;
    endcase
  end

  assign o_busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx. Two instances (one and two
//            stop bits) share randomized stimulus. Each instance has a
//            frame-level reference model that queues expected frames when a
//            request should be accepted, and a monitor that checks the line
//            tick by tick, the done pulse and the busy flag.
// Macro    : UART_TX_PARITY_EN - must match the RTL build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int N_DATA = 8;
  localparam int N_TICK = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct packed {
    logic [7:0]  data;
    logic [31:0] due;   // negedge index at which the start bit must appear
  } exp_t;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       valid    = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] data     = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;
  int valid_mode = 0;   // 0: every cycle, >0: every Nth cycle, <0: random
  int vcnt = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int MS          = g + 1;
    localparam int NBITS       = 1 + N_DATA + PAR + MS;
    localparam int FRAME_TICKS = NBITS * N_TICK;

    logic tx, done, busy;
    exp_t q[$];
    int   ticks_left = 0;
    int   pcount = 0;
    int   ncount = 0;
    logic exp_bits [0:15];
    bit   in_frame = 0;
    bit   done_due = 0;
    bit   post_reset = 0;
    int   consumed = 0;
    int   bit_err = 0;

    uart_tx #(
      .N_DATA(N_DATA), .LOG2_N_DATA(4), .M_STOP(MS), .LOG2_M_STOP(1), .N_TICK(N_TICK)
    ) dut (
      .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_data(data),
      .i_tx_start(tx_start), .o_tx(tx), .o_tx_done(done), .o_busy(busy)
    );

    // Reference model: a frame occupies FRAME_TICKS baud ticks after the
    // request is taken; requests while occupied are dropped.
    always @(posedge clk) begin
      exp_t e;
      pcount++;
      if (rst) begin
        ticks_left = 0;
      end else if (ticks_left == 0) begin
        if (tx_start) begin
          e.data = data;
          e.due  = pcount;
          q.push_back(e);
          ticks_left = FRAME_TICKS;
        end
      end else if (valid) begin
        ticks_left--;
      end
    end

    // Monitor: compares the line against the expected bit sequence, one
    // bit period = N_TICK ticks, and the done/busy flags every cycle.
    always @(negedge clk) begin
      exp_t  e;
      string tag;
      bit    was_done;
      int    pos;
      int    ones;
      ncount++;
      was_done = done_due;
      done_due = 0;

      if (!in_frame && q.size() > 0 && q[0].due == ncount) begin
        e = q.pop_front();
        ones = 0;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < N_DATA; i++) begin
          exp_bits[1 + i] = e.data[i];
          ones += int'(e.data[i]);
        end
        if (PAR == 1) exp_bits[1 + N_DATA] = 1'((ones % 2));
        for (int s = 0; s < MS; s++) exp_bits[1 + N_DATA + PAR + s] = 1'b1;
        in_frame = 1;
        consumed = 0;
        bit_err  = 0;
      end

      if (in_frame) begin
        pos = consumed / N_TICK;
        if (tx !== exp_bits[pos]) bit_err++;
        check($sformatf("cfg%0d busy_in_frame", g), 32'(busy), 32'd1);
        check($sformatf("cfg%0d done_in_frame", g), 32'(done), 32'd0);
        if (valid && !rst) begin
          consumed++;
          if (consumed % N_TICK == 0) begin
            check($sformatf("cfg%0d bit%0d(exp %0d) cycles_wrong", g, pos, exp_bits[pos]),
                  32'(bit_err), 32'd0);
            bit_err = 0;
            if (consumed == FRAME_TICKS) begin
              in_frame = 0;
              done_due = 1;
            end
          end
        end
      end else begin
        tag = post_reset ? "reset" : (was_done ? "done" : "idle");
        check($sformatf("cfg%0d %s_tx", g, tag), 32'(tx), 32'd1);
        check($sformatf("cfg%0d %s_busy", g, tag), 32'(busy), 32'd0);
        check($sformatf("cfg%0d %s_done", g, tag), 32'(done), 32'(was_done));
        post_reset = 0;
      end

      if (rst) begin
        in_frame   = 0;
        done_due   = 0;
        bit_err    = 0;
        post_reset = 1;
      end
    end
  end

  function automatic logic next_valid();
    vcnt++;
    if (valid_mode == 0) return 1'b1;
    if (valid_mode > 0) return (vcnt % valid_mode) == 0;
    return $urandom_range(0, 1) == 1;
  endfunction

  task automatic step(input logic start, input logic [7:0] d, input logic r);
    tx_start = start;
    data     = d;
    rst      = r;
    valid    = next_valid();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // Continuous ticks, single 0xA5 frame.
    valid_mode = 0;
    step(1'b1, 8'hA5, 1'b0);
    repeat (220) step(1'b0, 8'($urandom), 1'b0);

    // One tick every fourth cycle, 0x01.
    valid_mode = 4;
    vcnt = 0;
    step(1'b1, 8'h01, 1'b0);
    repeat (13 * 64 + 40) step(1'b0, 8'($urandom), 1'b0);

    // Request with 0xFF in the middle of a 0x3C frame must be dropped.
    valid_mode = 0;
    step(1'b1, 8'h3C, 1'b0);
    repeat (60) step(1'b0, 8'($urandom), 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    repeat (200) step(1'b0, 8'($urandom), 1'b0);

    // Reset while data bits are on the line.
    step(1'b1, 8'h5A, 1'b0);
    repeat (16 * 3 + 5) step(1'b0, 8'($urandom), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    repeat (40) step(1'b0, 8'($urandom), 1'b0);

    // Back-to-back: request held high, 0x55 first then 0xAA.
    step(1'b1, 8'h55, 1'b0);
    repeat (300) step(1'b1, 8'hAA, 1'b0);
    repeat (250) step(1'b0, 8'($urandom), 1'b0);

    // Random ticks, requests, data and occasional resets.
    valid_mode = -1;
    repeat (4000)
      step($urandom_range(0, 19) == 0, 8'($urandom), $urandom_range(0, 999) == 0);
    valid_mode = 0;
    repeat (300) step(1'b0, 8'($urandom), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
